// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and helpers for the stopwatch counter
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSED,
      ST_DONE
   } sw_state_t;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic logic [3:0] digit_max(input int i, input logic [31:0] mask);
      return mask[i[4:0]] ? 4'd5 : 4'd9;
   endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// rtl/bcd_updown_digit.sv - one BCD digit (0..9 or 0..5) with up/down step and carry/borrow out
module bcd_updown_digit
   import stopwatch_pkg::*;
#(
   parameter bit IS_RADIX6 = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dir,
   input  logic       load,
   input  logic       clear,
   input  logic [3:0] preset,
   output logic [3:0] value,
   output logic       carry_out,
   output logic       borrow_out
);

   localparam logic [3:0] MAX = digit_max(0, {31'b0, IS_RADIX6});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= preset;
      end else if (en) begin
         if (dir) value <= (value == 4'd0) ? MAX : value - 4'd1;
         else     value <= (value == MAX)  ? 4'd0 : value + 4'd1;
      end
   end

   assign carry_out  = en && !dir && (value == MAX);
   assign borrow_out = en &&  dir && (value == 4'd0);

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - synchronous N-digit mixed-radix BCD stopwatch with lap freeze and countdown
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int              CLK_HZ      = 50_000_000,
   parameter int              TICK_HZ     = 1000,
   parameter int              NDIG        = 7,
   parameter logic [NDIG-1:0] RADIX6_MASK = 7'b1010000
) (
   input  logic                clk_50Mhz,
   input  logic                rst,
   input  logic                start,
   input  logic                pause,
   input  logic                clear,
   input  logic                load,
   input  logic                dir,
   input  logic                lap,
   input  logic [4*NDIG-1:0]   preset,
   output logic [4*NDIG-1:0]   dispbuf,
   output logic                running,
   output logic                lap_active,
   output logic                wrap,
   output logic                done
);

   localparam int              DIV  = calc_div(CLK_HZ, TICK_HZ);
   localparam int              PW   = $clog2(DIV);
   localparam logic [PW-1:0]   LAST = PW'(DIV - 1);
   localparam logic [4*NDIG-1:0] ONE = (4*NDIG)'(1);

   sw_state_t          state;
   logic [PW-1:0]      presc;
   logic [4*NDIG-1:0]  count;
   logic [4*NDIG-1:0]  lap_reg;
   logic [4*NDIG-1:0]  preset_clamped;
   logic [NDIG-1:0]    en_chain;
   logic [NDIG-1:0]    carry;
   logic [NDIG-1:0]    borrow;
   logic               tick;
   logic               cmd_reset;
   logic               to_zero;
   logic               unused_borrow_msb;

   assign cmd_reset         = clear || load;
   assign tick              = (state == ST_RUN) && (presc == LAST);
   // A down step from exactly ...0001 is the only step that lands on all-zero.
   assign to_zero           = en_chain[0] && dir && (count == ONE);
   assign unused_borrow_msb = borrow[NDIG-1];

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      localparam logic [3:0] DMAX = digit_max(i, 32'(RADIX6_MASK));

      assign preset_clamped[4*i +: 4] = (preset[4*i +: 4] > DMAX) ? DMAX : preset[4*i +: 4];

      if (i == 0) begin : g_lsd
         assign en_chain[i] = tick && !cmd_reset;
      end else begin : g_upper
         assign en_chain[i] = carry[i-1] | borrow[i-1];
      end

      bcd_updown_digit #(
         .IS_RADIX6(RADIX6_MASK[i])
      ) u_digit (
         .clk        (clk_50Mhz),
         .rst        (rst),
         .en         (en_chain[i]),
         .dir        (dir),
         .load       (load),
         .clear      (clear),
         .preset     (preset_clamped[4*i +: 4]),
         .value      (count[4*i +: 4]),
         .carry_out  (carry[i]),
         .borrow_out (borrow[i])
      );
   end

   always_ff @(posedge clk_50Mhz or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         presc      <= '0;
         lap_reg    <= '0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
         done       <= 1'b0;
      end else begin
         wrap <= carry[NDIG-1];
         done <= 1'b0;

         if (state == ST_RUN) presc <= tick ? '0 : presc + 1'b1;

         if (cmd_reset) begin
            state <= ST_IDLE;
            presc <= '0;
         end else if (to_zero) begin
            state <= ST_DONE;
            done  <= 1'b1;
         end else if (pause) begin
            if (state == ST_RUN) state <= ST_PAUSED;
         end else if (start && state != ST_RUN) begin
            if (dir && count == '0) begin
               state <= ST_DONE;
               done  <= 1'b1;
            end else begin
               state <= ST_RUN;
            end
         end

         // lap_reg captures the pre-tick count when lap and tick coincide.
         if (cmd_reset) begin
            lap_active <= 1'b0;
         end else if (lap) begin
            if (lap_active) begin
               lap_active <= 1'b0;
            end else if (state == ST_RUN || state == ST_PAUSED) begin
               lap_reg    <= count;
               lap_active <= 1'b1;
            end
         end
      end
   end

   assign dispbuf = lap_active ? lap_reg : count;
   assign running = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - table-driven scoreboard bench for stopwatch_core
module tb_stopwatch_core;

   localparam logic [5:0] C_ST = 6'b100000;
   localparam logic [5:0] C_PA = 6'b010000;
   localparam logic [5:0] C_CL = 6'b001000;
   localparam logic [5:0] C_LD = 6'b000100;
   localparam logic [5:0] C_LP = 6'b000010;
   localparam logic [5:0] C_DR = 6'b000001;
   localparam logic [3:0] E_RUN  = 4'b1000;
   localparam logic [3:0] E_LAP  = 4'b0100;
   localparam logic [3:0] E_WRAP = 4'b0010;
   localparam logic [3:0] E_DONE = 4'b0001;

   typedef struct {
      string       name;
      logic [5:0]  cmd;
      logic [27:0] pre;
      int          wt;
      logic [27:0] e_disp;
      logic [3:0]  e_out;
   } vec_t;

   typedef struct {
      string       name;
      logic [27:0] disp;
      logic [3:0]  outs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        start, pause, clear, load, dir, lap;
   logic [27:0] preset, dispbuf;
   logic        running, lap_active, wrap, done;

   logic        b_start, b_load, b_dir;
   logic [15:0] b_preset, b_disp;
   logic        b_running, b_lap_active, b_wrap, b_done;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb[$];
   vec_t tbl[$];

   stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .NDIG(7), .RADIX6_MASK(7'b1010000)) dut (
      .clk_50Mhz(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
      .load(load), .dir(dir), .lap(lap), .preset(preset), .dispbuf(dispbuf),
      .running(running), .lap_active(lap_active), .wrap(wrap), .done(done)
   );

   stopwatch_core #(.CLK_HZ(2), .TICK_HZ(1), .NDIG(4), .RADIX6_MASK(4'b0000)) dut_b (
      .clk_50Mhz(clk), .rst(rst), .start(b_start), .pause(1'b0), .clear(1'b0),
      .load(b_load), .dir(b_dir), .lap(1'b0), .preset(b_preset), .dispbuf(b_disp),
      .running(b_running), .lap_active(b_lap_active), .wrap(b_wrap), .done(b_done)
   );

   function automatic vec_t mk(input string n, input logic [5:0] c, input logic [27:0] p,
                               input int w, input logic [27:0] ed, input logic [3:0] eo);
      vec_t v;
      v.name = n; v.cmd = c; v.pre = p; v.wt = w; v.e_disp = ed; v.e_out = eo;
      return v;
   endfunction

   task automatic expect_push(input string n, input logic [27:0] d, input logic [3:0] o);
      exp_t e;
      e.name = n; e.disp = d; e.outs = o;
      sb.push_back(e);
   endtask

   task automatic check_sb(input logic [27:0] d, input logic [3:0] o);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty");
         return;
      end
      e = sb.pop_front();
      if (d !== e.disp) begin
         n_fail++;
         $display("FAIL %s dispbuf actual=%h required=%h", e.name, d, e.disp);
      end
      n_tests++;
      if (o !== e.outs) begin
         n_fail++;
         $display("FAIL %s run/lap/wrap/done actual=%b required=%b", e.name, o, e.outs);
      end
   endtask

   task automatic apply(input vec_t v);
      {start, pause, clear, load, lap, dir} = v.cmd;
      preset = v.pre;
      @(negedge clk);
      {start, pause, clear, load, lap} = '0;
      repeat (v.wt) @(negedge clk);
      expect_push(v.name, v.e_disp, v.e_out);
      check_sb(dispbuf, {running, lap_active, wrap, done});
   endtask

   task automatic check_b(input string n, input logic [15:0] d, input logic [3:0] o);
      expect_push(n, {12'h0, d}, o);
      check_sb({12'h0, b_disp}, {b_running, b_lap_active, b_wrap, b_done});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      {start, pause, clear, load, lap, dir} = '0;
      preset = '0;
      {b_start, b_load, b_dir} = '0;
      b_preset = '0;

      tbl.push_back(mk("start",     C_ST,             28'h0, 0,   28'h0000000, E_RUN));
      tbl.push_back(mk("run25",     6'b0,             28'h0, 249, 28'h0000025, E_RUN));
      tbl.push_back(mk("pause",     C_PA,             28'h0, 0,   28'h0000025, 4'b0));
      tbl.push_back(mk("hold100",   6'b0,             28'h0, 99,  28'h0000025, 4'b0));
      tbl.push_back(mk("resume",    C_ST,             28'h0, 0,   28'h0000025, E_RUN));
      tbl.push_back(mk("phase_kept",6'b0,             28'h0, 7,   28'h0000025, E_RUN));
      tbl.push_back(mk("tick26",    6'b0,             28'h0, 0,   28'h0000026, E_RUN));
      tbl.push_back(mk("ld_max",    C_LD,     28'h5959999, 0,   28'h5959999, 4'b0));
      tbl.push_back(mk("st_up",     C_ST,             28'h0, 0,   28'h5959999, E_RUN));
      tbl.push_back(mk("pre_wrap",  6'b0,             28'h0, 8,   28'h5959999, E_RUN));
      tbl.push_back(mk("wrap",      6'b0,             28'h0, 0,   28'h0000000, E_RUN | E_WRAP));
      tbl.push_back(mk("wrap_end",  6'b0,             28'h0, 0,   28'h0000000, E_RUN));
      tbl.push_back(mk("ld3",       C_LD | C_DR,      28'h3, 0,   28'h0000003, 4'b0));
      tbl.push_back(mk("dn2",       C_ST | C_DR,      28'h0, 10,  28'h0000002, E_RUN));
      tbl.push_back(mk("dn1",       C_DR,             28'h0, 9,   28'h0000001, E_RUN));
      tbl.push_back(mk("dn0_done",  C_DR,             28'h0, 9,   28'h0000000, E_DONE));
      tbl.push_back(mk("done_end",  C_DR,             28'h0, 0,   28'h0000000, 4'b0));
      tbl.push_back(mk("done_hold", C_DR,             28'h0, 20,  28'h0000000, 4'b0));
      tbl.push_back(mk("st_zero",   C_ST | C_DR,      28'h0, 0,   28'h0000000, E_DONE));
      tbl.push_back(mk("st_zero_end",C_DR,            28'h0, 0,   28'h0000000, 4'b0));
      tbl.push_back(mk("ld_clamp",  C_LD | C_DR,  28'hFFFFFFF, 0, 28'h5959999, 4'b0));
      tbl.push_back(mk("clr_prio",  C_CL|C_LD|C_ST, 28'h1234567, 0, 28'h0000000, 4'b0));
      tbl.push_back(mk("lap_idle",  C_LP,             28'h0, 0,   28'h0000000, 4'b0));
      tbl.push_back(mk("ld10",      C_LD,            28'h10, 0,   28'h0000010, 4'b0));
      tbl.push_back(mk("st10",      C_ST,             28'h0, 5,   28'h0000010, E_RUN));
      tbl.push_back(mk("lap_on",    C_LP,             28'h0, 0,   28'h0000010, E_RUN | E_LAP));
      tbl.push_back(mk("lap_frozen",6'b0,             28'h0, 43,  28'h0000010, E_RUN | E_LAP));
      tbl.push_back(mk("lap_rel",   C_LP,             28'h0, 0,   28'h0000015, E_RUN));
      tbl.push_back(mk("lap_on2",   C_LP,             28'h0, 3,   28'h0000015, E_RUN | E_LAP));

      repeat (3) @(negedge clk);
      expect_push("reset", 28'h0, 4'b0);
      check_sb(dispbuf, {running, lap_active, wrap, done});
      rst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

      // asynchronous reset while running with lap frozen
      #2 rst = 1'b0;
      #1;
      expect_push("async_rst", 28'h0, 4'b0);
      check_sb(dispbuf, {running, lap_active, wrap, done});
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 4-digit decimal instance, DIV = 2
      b_load = 1'b1; b_preset = 16'h9998; b_dir = 1'b0;
      @(negedge clk);
      b_load = 1'b0; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check_b("b_start", 16'h9998, E_RUN);
      @(negedge clk);
      @(negedge clk);
      check_b("b_9999", 16'h9999, E_RUN);
      @(negedge clk);
      @(negedge clk);
      check_b("b_wrap", 16'h0000, E_RUN | E_WRAP);
      b_dir = 1'b1;
      @(negedge clk);
      check_b("b_wrap_end", 16'h0000, E_RUN);
      @(negedge clk);
      check_b("b_down_first", 16'h9999, E_RUN);
      @(negedge clk);
      @(negedge clk);
      check_b("b_down_second", 16'h9998, E_RUN);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
